// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider: one trial subtraction per clock,
// start/busy/done handshake, result registers held until the next result.
module seq_restoring_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             divByZero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    FIN  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] qOut_q, qOut_d;
  logic [WIDTH-1:0] rOut_q, rOut_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   remShift;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] quoShift;
  logic [WIDTH-1:0] remNext;

  // The remainder stays below the divisor, so its top (WIDTH+1-th) bit is
  // always zero between steps and only the shifted value needs the extra bit.
  always_comb begin
    remShift = {rem_q, quo_q[WIDTH-1]};
    trial    = remShift - {1'b0, divisor_q};
    quoShift = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
    remNext  = trial[WIDTH] ? remShift[WIDTH-1:0] : trial[WIDTH-1:0];
  end

  always_comb begin
    state_d   = state_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    divisor_d = divisor_q;
    cnt_d     = cnt_q;
    qOut_d    = qOut_q;
    rOut_d    = rOut_q;
    dbz_d     = dbz_q;

    case (state_q)
      IDLE, FIN: begin
        if (start) begin
          quo_d     = A;
          divisor_d = B;
          rem_d     = '0;
          cnt_d     = '0;
          if (B != '0) begin
            state_d = DIV;
          end else begin
            state_d = FIN;
            qOut_d  = '1;
            rOut_d  = A;
            dbz_d   = 1'b1;
          end
        end else if (state_q == FIN) begin
          state_d = IDLE;
        end
      end

      DIV: begin
        quo_d = quoShift;
        rem_d = remNext;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = FIN;
          qOut_d  = quoShift;
          rOut_d  = remNext;
          dbz_d   = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      quo_q     <= '0;
      rem_q     <= '0;
      divisor_q <= '0;
      cnt_q     <= '0;
      qOut_q    <= '0;
      rOut_q    <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      divisor_q <= divisor_d;
      cnt_q     <= cnt_d;
      qOut_q    <= qOut_d;
      rOut_q    <= rOut_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy      = (state_q == DIV);
  assign done      = (state_q == FIN);
  assign Q         = qOut_q;
  assign R         = rOut_q;
  assign divByZero = dbz_q;

endmodule
